// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates jtag reset, interrupt, execute jump, halt and stalls
// into registered PC redirect, hold level and core-reset controls.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned RST_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_req_ex_i,
  input  logic [31:0] jump_addr_ex_i,
  input  logic        int_req_i,
  input  logic [31:0] int_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  input  logic        jtag_halt_req_i,
  input  logic        jtag_reset_req_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [2:0]  hold_flag_o,
  output logic        jtag_reset_flag_o,
  output logic        int_ack_o,
  output logic        halted_o
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
    $error("pipe_ctrl: FLUSH_CYCLES must be in 1..15");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > 15) begin : g_bad_rst_cycles
    $error("pipe_ctrl: RST_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2,
    S_JRST  = 2'd3
  } state_e;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  // Counters hold the number of cycles still to run after the one being entered.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [3:0] RST_LOAD   = 4'(RST_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        jump_flag_q, jump_flag_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic [2:0]  hold_q, hold_d;
  logic        jrst_q, jrst_d;
  logic        ack_q, ack_d;
  logic        halted_q, halted_d;

  logic [2:0]  stall_lvl;
  logic        redirect_ok;
  logic        int_take;
  logic        jump_take;

  assign stall_lvl   = hold_ex_i ? HOLD_ID : (hold_bus_i ? HOLD_PC : HOLD_NONE);
  // Blocking a redirect right after another keeps jump_flag/int_ack single-cycle.
  assign redirect_ok = !jump_flag_q;
  assign int_take    = int_req_i && !hold_ex_i && redirect_ok;
  assign jump_take   = jump_req_ex_i && redirect_ok;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jump_flag_d = 1'b0;
    jump_addr_d = jump_addr_q;
    hold_d      = HOLD_NONE;
    jrst_d      = 1'b0;
    ack_d       = 1'b0;
    halted_d    = 1'b0;

    if (jtag_reset_req_i) begin
      state_d = S_JRST;
      cnt_d   = RST_LOAD;
      jrst_d  = 1'b1;
      hold_d  = HOLD_ID;
    end else begin
      case (state_q)
        S_JRST: begin
          if (cnt_q != 4'd0) begin
            cnt_d  = cnt_q - 4'd1;
            jrst_d = 1'b1;
            hold_d = HOLD_ID;
          end else if (jtag_halt_req_i) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            hold_d   = HOLD_ID;
          end else begin
            state_d = S_RUN;
            hold_d  = stall_lvl;
          end
        end
        S_HALT: begin
          if (jtag_halt_req_i) begin
            halted_d = 1'b1;
            hold_d   = HOLD_ID;
          end else begin
            state_d = S_RUN;
            hold_d  = stall_lvl;
          end
        end
        default: begin
          if (int_take) begin
            state_d     = S_FLUSH;
            cnt_d       = FLUSH_LOAD;
            jump_flag_d = 1'b1;
            jump_addr_d = int_addr_i;
            ack_d       = 1'b1;
          end else if (jump_take) begin
            state_d     = S_FLUSH;
            cnt_d       = FLUSH_LOAD;
            jump_flag_d = 1'b1;
            jump_addr_d = jump_addr_ex_i;
          end else if (state_q == S_FLUSH && cnt_q != 4'd0) begin
            cnt_d  = cnt_q - 4'd1;
            hold_d = (stall_lvl == HOLD_ID) ? HOLD_ID : HOLD_IF;
          end else if (jtag_halt_req_i && !hold_ex_i) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            hold_d   = HOLD_ID;
          end else begin
            state_d = S_RUN;
            hold_d  = stall_lvl;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= 4'd0;
      jump_flag_q <= 1'b0;
      jump_addr_q <= 32'h0;
      hold_q      <= HOLD_NONE;
      jrst_q      <= 1'b0;
      ack_q       <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
      hold_q      <= hold_d;
      jrst_q      <= jrst_d;
      ack_q       <= ack_d;
      halted_q    <= halted_d;
    end
  end

  assign jump_flag_o       = jump_flag_q;
  assign jump_addr_o       = jump_addr_q;
  assign hold_flag_o       = hold_q;
  assign jtag_reset_flag_o = jrst_q;
  assign int_ack_o         = ack_q;
  assign halted_o          = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: a per-cycle table of inputs and hand-computed
// outputs, plus hand-written jtag-reset and asynchronous-reset sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_req_ex_i;
  logic [31:0] jump_addr_ex_i;
  logic        int_req_i;
  logic [31:0] int_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        jtag_halt_req_i;
  logic        jtag_reset_req_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;
  logic        jtag_reset_flag_o;
  logic        int_ack_o;
  logic        halted_o;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_ctrl #(.FLUSH_CYCLES(1), .RST_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .jump_req_ex_i     (jump_req_ex_i),
    .jump_addr_ex_i    (jump_addr_ex_i),
    .int_req_i         (int_req_i),
    .int_addr_i        (int_addr_i),
    .hold_ex_i         (hold_ex_i),
    .hold_bus_i        (hold_bus_i),
    .jtag_halt_req_i   (jtag_halt_req_i),
    .jtag_reset_req_i  (jtag_reset_req_i),
    .jump_flag_o       (jump_flag_o),
    .jump_addr_o       (jump_addr_o),
    .hold_flag_o       (hold_flag_o),
    .jtag_reset_flag_o (jtag_reset_flag_o),
    .int_ack_o         (int_ack_o),
    .halted_o          (halted_o)
  );

  always #5 clk = ~clk;

  // Output bundle: {jump_flag, jump_addr[31:0], hold[2:0], jtag_reset_flag, int_ack, halted}
  typedef struct {
    logic        jr;
    logic [31:0] ja;
    logic        ir;
    logic [31:0] ia;
    logic        hx;
    logic        hb;
    logic        ht;
    logic        jt;
    logic [38:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic jr, logic [31:0] ja, logic ir, logic [31:0] ia,
                              logic hx, logic hb, logic ht, logic jt,
                              logic ejf, logic [31:0] eaddr, logic [2:0] eh,
                              logic ejr, logic eack, logic ehalt);
    vec_t v;
    v.jr = jr; v.ja = ja; v.ir = ir; v.ia = ia;
    v.hx = hx; v.hb = hb; v.ht = ht; v.jt = jt;
    v.exp = {ejf, eaddr, eh, ejr, eack, ehalt};
    return v;
  endfunction

  function automatic logic [38:0] outs();
    return {jump_flag_o, jump_addr_o, hold_flag_o, jtag_reset_flag_o, int_ack_o, halted_o};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got jf=%b addr=%h hold=%0d jrst=%b ack=%b halted=%b, want jf=%b addr=%h hold=%0d jrst=%b ack=%b halted=%b",
               name, act[38], act[37:6], act[5:3], act[2], act[1], act[0],
               exp[38], exp[37:6], exp[5:3], exp[2], exp[1], exp[0]);
    end else begin
      $display("%s: jf=%b addr=%h hold=%0d jrst=%b ack=%b halted=%b",
               name, act[38], act[37:6], act[5:3], act[2], act[1], act[0]);
    end
  endtask

  task automatic drive(input vec_t v);
    jump_req_ex_i    = v.jr;
    jump_addr_ex_i   = v.ja;
    int_req_i        = v.ir;
    int_addr_i       = v.ia;
    hold_ex_i        = v.hx;
    hold_bus_i       = v.hb;
    jtag_halt_req_i  = v.ht;
    jtag_reset_req_i = v.jt;
  endtask

  // Drive after an edge, let the next edge sample, compare 1 time unit later.
  task automatic run_vec(input vec_t v, input string name);
    drive(v);
    @(posedge clk);
    #1;
    check(name, outs(), v.exp);
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 39'h0);
    rst = 1'b0;

    //                jr ja            ir ia            hx hb ht jt   jf addr          h  jrs ack hlt
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h0,        0, 0, 0, 0)); // 0 idle
    vecs.push_back(mk(1, 32'h100,      0, 32'h0,        0, 0, 0, 0,   1, 32'h100,      0, 0, 0, 0)); // 1 ex jump
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h100,      2, 0, 0, 0)); // 2 flush bubble
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h100,      0, 0, 0, 0)); // 3 run
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 0,   0, 32'h100,      1, 0, 0, 0)); // 4 bus stall
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0, 0, 0,   0, 32'h100,      3, 0, 0, 0)); // 5 ex stall
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 1, 0, 0,   0, 32'h100,      3, 0, 0, 0)); // 6 both stalls
    vecs.push_back(mk(1, 32'h200,      1, 32'h80,       0, 0, 0, 0,   1, 32'h80,       0, 0, 1, 0)); // 7 int beats jump
    vecs.push_back(mk(1, 32'h300,      1, 32'h80,       0, 0, 0, 0,   0, 32'h80,       2, 0, 0, 0)); // 8 no back-to-back redirect
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h80,       0, 0, 0, 0)); // 9 run
    vecs.push_back(mk(0, 32'h0,        1, 32'hC0,       1, 0, 0, 0,   0, 32'h80,       3, 0, 0, 0)); // 10 int blocked by ex stall
    vecs.push_back(mk(0, 32'h0,        1, 32'hC0,       1, 0, 0, 0,   0, 32'h80,       3, 0, 0, 0)); // 11
    vecs.push_back(mk(0, 32'h0,        1, 32'hC0,       1, 0, 0, 0,   0, 32'h80,       3, 0, 0, 0)); // 12
    vecs.push_back(mk(0, 32'h0,        1, 32'hC0,       1, 0, 0, 0,   0, 32'h80,       3, 0, 0, 0)); // 13
    vecs.push_back(mk(0, 32'h0,        1, 32'hC0,       1, 0, 0, 0,   0, 32'h80,       3, 0, 0, 0)); // 14
    vecs.push_back(mk(0, 32'h0,        1, 32'hC0,       0, 0, 0, 0,   1, 32'hC0,       0, 0, 1, 0)); // 15 int accepted
    vecs.push_back(mk(0, 32'h0,        1, 32'hC0,       0, 0, 0, 0,   0, 32'hC0,       2, 0, 0, 0)); // 16 no second ack
    vecs.push_back(mk(1, 32'h400,      0, 32'h0,        0, 0, 0, 0,   1, 32'h400,      0, 0, 0, 0)); // 17 jump inside flush
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 0,   0, 32'h400,      2, 0, 0, 0)); // 18 flush max(2,1)
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h400,      0, 0, 0, 0)); // 19
    vecs.push_back(mk(1, 32'h500,      0, 32'h0,        0, 0, 0, 0,   1, 32'h500,      0, 0, 0, 0)); // 20 jump
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0, 0, 0,   0, 32'h500,      3, 0, 0, 0)); // 21 flush max(2,3)
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h500,      0, 0, 0, 0)); // 22
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 0,   0, 32'h500,      3, 0, 0, 1)); // 23 halt
    vecs.push_back(mk(0, 32'h0,        1, 32'h600,      0, 0, 1, 0,   0, 32'h500,      3, 0, 0, 1)); // 24 int ignored
    vecs.push_back(mk(1, 32'h700,      1, 32'h600,      0, 0, 1, 0,   0, 32'h500,      3, 0, 0, 1)); // 25 jump ignored
    vecs.push_back(mk(0, 32'h0,        1, 32'h600,      0, 0, 0, 0,   0, 32'h500,      0, 0, 0, 0)); // 26 release
    vecs.push_back(mk(0, 32'h0,        1, 32'h600,      0, 0, 0, 0,   1, 32'h600,      0, 0, 1, 0)); // 27 pending int
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h600,      2, 0, 0, 0)); // 28
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h600,      0, 0, 0, 0)); // 29
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0, 1, 0,   0, 32'h600,      3, 0, 0, 0)); // 30 halt waits on ex stall
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 1, 0,   0, 32'h600,      3, 0, 0, 1)); // 31 halt
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 0, 0, 0,   0, 32'h600,      0, 0, 0, 0)); // 32 release

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // jtag reset pulse during FLUSH: flag for exactly two cycles, then RUN.
    run_vec(mk(1, 32'h800, 0, 32'h0, 0, 0, 0, 0,   1, 32'h800, 0, 0, 0, 0), "jrst_a_jump");
    run_vec(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 1,   0, 32'h800, 3, 1, 0, 0), "jrst_a_c1");
    run_vec(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 0,   0, 32'h800, 3, 1, 0, 0), "jrst_a_c2");
    run_vec(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 0,   0, 32'h800, 0, 0, 0, 0), "jrst_a_exit");
    run_vec(mk(0, 32'h0,   0, 32'h0, 0, 0, 0, 0,   0, 32'h800, 0, 0, 0, 0), "jrst_a_run");

    // Re-request reloads the counter; int discarded; exit into HALT.
    run_vec(mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 1,   0, 32'h800, 3, 1, 0, 0), "jrst_b_c1");
    run_vec(mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 1,   0, 32'h800, 3, 1, 0, 0), "jrst_b_reload");
    run_vec(mk(1, 32'h999, 1, 32'h900, 0, 0, 1, 0,   0, 32'h800, 3, 1, 0, 0), "jrst_b_c3");
    run_vec(mk(0, 32'h0,   1, 32'h900, 0, 0, 1, 0,   0, 32'h800, 3, 0, 0, 1), "jrst_b_to_halt");
    run_vec(mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 0,   0, 32'h800, 0, 0, 0, 0), "jrst_b_release");

    // Asynchronous reset between edges while halted.
    run_vec(mk(0, 32'h0, 0, 32'h0, 0, 0, 1, 0,   0, 32'h800, 3, 0, 0, 1), "areset_halt");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("areset_immediate", outs(), 39'h0);
    drive(mk(0,0, 1,32'hA00, 0,0,0,1, 0,0,0,0,0,0));
    @(posedge clk);
    #1;
    check("areset_held", outs(), 39'h0);
    drive(mk(0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0));
    rst = 1'b0;
    run_vec(mk(0, 32'h0, 0, 32'h0, 0, 0, 0, 0,   0, 32'h0, 0, 0, 0, 0), "areset_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
